// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round-level sequencer.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } seqState_t;

  localparam int          NR_DEFAULT = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  RCON_POLY  = 8'h1B;

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads the first Rcon and advances by xtime in GF(2^8).
module aes_rcon_gen
  import aes_seq_pkg::*;
(
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       InitxSI,
  input  logic       AdvancexSI,
  output logic [7:0] RconxDO
);

  logic [7:0] RconxDP, RconxDN;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

  always_comb begin
    RconxDN = RconxDP;
    if (InitxSI) begin
      RconxDN = RCON_INIT;
    end else if (AdvancexSI) begin
      RconxDN = xtime(RconxDP);
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      RconxDP <= RCON_INIT;
    end else begin
      RconxDP <= RconxDN;
    end
  end

  assign RconxDO = RconxDP;

endmodule

// File: rtl/aes_round_seq.sv
// Round-level sequencer: accepts a host request, starts the step controller,
// counts rounds on ShiftRows, drives Rcon/LastRound and hands back the result.
module aes_round_seq
  import aes_seq_pkg::*;
#(
  parameter int NR      = NR_DEFAULT,
  parameter int ROUND_W = 4
) (
  input  logic               ClkxCI,
  input  logic               RstxBI,
  input  logic               InValidxSI,
  output logic               InReadyxSO,
  output logic               LoadxSO,
  input  logic               StateIDLExSI,
  input  logic               StateSHIFTROWSxSI,
  output logic               StartxSO,
  output logic               LastRoundxSO,
  output logic [7:0]         RconxDO,
  output logic [ROUND_W-1:0] RoundxDO,
  output logic               OutValidxSO,
  input  logic               OutReadyxSI,
  output logic               ErrxSO
);

  localparam logic [ROUND_W-1:0] RoundLast = ROUND_W'(NR);
  localparam logic [ROUND_W-1:0] RoundOne  = ROUND_W'(1);

  seqState_t          StatexDP, StatexDN;
  logic [ROUND_W-1:0] RoundxDP, RoundxDN;
  logic               ErrxDP, ErrxDN;
  logic               RconInitxS, RconAdvxS;

  always_comb begin
    StatexDN     = StatexDP;
    RoundxDN     = RoundxDP;
    ErrxDN       = ErrxDP;
    InReadyxSO   = 1'b0;
    LoadxSO      = 1'b0;
    StartxSO     = 1'b0;
    LastRoundxSO = 1'b0;
    OutValidxSO  = 1'b0;
    RconInitxS   = 1'b0;
    RconAdvxS    = 1'b0;

    case (StatexDP)
      StIdle: begin
        InReadyxSO = 1'b1;
        if (InValidxSI) begin
          LoadxSO    = 1'b1;
          RconInitxS = 1'b1;
          RoundxDN   = RoundOne;
          ErrxDN     = 1'b0;
          StatexDN   = StLoad;
        end
      end

      StLoad: begin
        // Start only when the step controller can take it, so it is never lost.
        StartxSO = StateIDLExSI;
        if (StateIDLExSI) begin
          StatexDN = StRun;
        end
      end

      StRun: begin
        LastRoundxSO = (RoundxDP == RoundLast);
        if (StateIDLExSI) begin
          // Controller fell back to idle mid-encryption: abort without a result.
          ErrxDN   = 1'b1;
          RoundxDN = '0;
          StatexDN = StIdle;
        end else if (StateSHIFTROWSxSI) begin
          if (RoundxDP == RoundLast) begin
            StatexDN = StDone;
          end else begin
            RoundxDN  = RoundxDP + RoundOne;
            RconAdvxS = 1'b1;
          end
        end
      end

      StDone: begin
        OutValidxSO = 1'b1;
        if (OutReadyxSI) begin
          RoundxDN = '0;
          StatexDN = StIdle;
        end
      end

      default: begin
        RoundxDN = '0;
        StatexDN = StIdle;
      end
    endcase
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP <= StIdle;
      RoundxDP <= '0;
      ErrxDP   <= 1'b0;
    end else begin
      StatexDP <= StatexDN;
      RoundxDP <= RoundxDN;
      ErrxDP   <= ErrxDN;
    end
  end

  aes_rcon_gen uRconGen (
    .ClkxCI     (ClkxCI),
    .RstxBI     (RstxBI),
    .InitxSI    (RconInitxS),
    .AdvancexSI (RconAdvxS),
    .RconxDO    (RconxDO)
  );

  assign RoundxDO = RoundxDP;
  assign ErrxSO   = ErrxDP;

endmodule
